// File: rtl/priority_encoder8to3_if.sv
// Request/grant bus of the 8-to-3 priority encoder.
// The producer/consumer side (master) drives requests and acknowledges;
// the encoder side (slave) presents the grant code and status.
interface priority_encoder8to3_if;
    logic       en;
    logic [7:0] req;
    logic       ack;
    logic [2:0] code;
    logic       valid;
    logic [7:0] pending;
    logic       lost;

    modport master (
        output en, req, ack,
        input  code, valid, pending, lost
    );

    modport slave (
        input  en, req, ack,
        output code, valid, pending, lost
    );
endinterface

// File: rtl/priority_encoder8to3.sv
// Registered 8-to-3 priority encoder with a pending-request vector and a
// valid/ack handshake. A presented grant is held until acknowledged and is
// never preempted. The code bits are index-reversed: code[0] carries the
// index MSB and code[2] the index LSB.
module priority_encoder8to3 #(
    parameter int HIGH_FIRST = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    priority_encoder8to3_if.slave  bus
);

    typedef enum logic {IDLE, PRESENT} state_t;

    state_t     state_q, state_d;
    logic [2:0] code_q, code_d;
    logic [7:0] pending_q, pending_d;
    logic       lost_q, lost_d;
    logic [7:0] set_vec;
    logic [7:0] clr_vec;

    // Highest-priority set bit of vec; ties resolved by HIGH_FIRST.
    function automatic logic [2:0] pick_index(input logic [7:0] vec);
        logic [2:0] idx;
        idx = 3'd0;
        if (HIGH_FIRST != 0) begin
            for (int i = 0; i < 8; i++) begin
                if (vec[i]) idx = 3'(i);
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (vec[i]) idx = 3'(i);
            end
        end
        return idx;
    endfunction

    // Index <-> code mapping is a bit reversal in both directions.
    function automatic logic [2:0] swap_bits(input logic [2:0] v);
        return {v[0], v[1], v[2]};
    endfunction

    // Next-state, grant selection and pending-vector update.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        clr_vec = '0;
        case (state_q)
            IDLE: begin
                if (|pending_q) begin
                    code_d  = swap_bits(pick_index(pending_q));
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (bus.ack) begin
                    clr_vec = 8'(1) << swap_bits(code_q);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A set on the same edge as a clear wins, and does not count as lost.
        set_vec   = bus.en ? bus.req : '0;
        pending_d = (pending_q & ~clr_vec) | set_vec;
        lost_d    = |(set_vec & pending_q & ~clr_vec);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            code_q    <= '0;
            pending_q <= '0;
            lost_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            pending_q <= pending_d;
            lost_q    <= lost_d;
        end
    end

    assign bus.code    = code_q;
    assign bus.valid   = (state_q == PRESENT);
    assign bus.pending = pending_q;
    assign bus.lost    = lost_q;

endmodule

// File: tb/tb_priority_encoder8to3.sv
// Bench for priority_encoder8to3: one instance per HIGH_FIRST setting.
// Stimulus pushes expected grant codes into a queue per instance; a monitor
// pops one on every new presentation and checks the code stays stable.
module tb_priority_encoder8to3;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    priority_encoder8to3_if ifa ();
    priority_encoder8to3_if ifb ();

    priority_encoder8to3 #(.HIGH_FIRST(1)) dut_a (.clk(clk), .reset(rst_a), .bus(ifa));
    priority_encoder8to3 #(.HIGH_FIRST(0)) dut_b (.clk(clk), .reset(rst_b), .bus(ifb));

    logic [2:0] expq_a[$];
    logic [2:0] expq_b[$];
    logic [2:0] cur_a, cur_b;
    logic       pv_a = 1'b0;
    logic       pv_b = 1'b0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor for the HIGH_FIRST=1 instance.
    always @(negedge clk) begin
        if (ifa.valid && !pv_a) begin
            if (expq_a.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL grant_a: unexpected code %b, none expected", ifa.code);
            end else begin
                cur_a = expq_a.pop_front();
                chk("grant_a", 8'(ifa.code), 8'(cur_a));
            end
        end else if (ifa.valid && pv_a) begin
            chk("hold_a", 8'(ifa.code), 8'(cur_a));
        end
        pv_a = ifa.valid;
    end

    // Monitor for the HIGH_FIRST=0 instance.
    always @(negedge clk) begin
        if (ifb.valid && !pv_b) begin
            if (expq_b.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL grant_b: unexpected code %b, none expected", ifb.code);
            end else begin
                cur_b = expq_b.pop_front();
                chk("grant_b", 8'(ifb.code), 8'(cur_b));
            end
        end else if (ifb.valid && pv_b) begin
            chk("hold_b", 8'(ifb.code), 8'(cur_b));
        end
        pv_b = ifb.valid;
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        ifa.en = 1'b0; ifa.req = 8'h00; ifa.ack = 1'b0;
        ifb.en = 1'b0; ifb.req = 8'h00; ifb.ack = 1'b0;
        step(); step();
        rst_a = 1'b0;
        chk("rst_pending", ifa.pending, 8'h00);
        chk("rst_valid",   8'(ifa.valid), 8'h00);
        chk("rst_code",    8'(ifa.code),  8'h00);
        chk("rst_lost",    8'(ifa.lost),  8'h00);

        // Single request, index 5 -> code 101.
        ifa.en = 1'b1; ifa.req = 8'h20; expq_a.push_back(3'b101);
        step();
        ifa.en = 1'b0; ifa.req = 8'h00;
        chk("single_pending", ifa.pending, 8'h20);
        chk("single_valid0",  8'(ifa.valid), 8'h00);
        step();
        chk("single_valid1",  8'(ifa.valid), 8'h01);
        ifa.ack = 1'b1;
        step();
        ifa.ack = 1'b0;
        chk("single_ack_valid",   8'(ifa.valid), 8'h00);
        chk("single_ack_pending", ifa.pending, 8'h00);

        // Priority 7 over 0; ack held through the bubble must be ignored.
        ifa.en = 1'b1; ifa.req = 8'h81;
        expq_a.push_back(3'b111); expq_a.push_back(3'b000);
        step();
        ifa.en = 1'b0; ifa.req = 8'h00;
        step();
        ifa.ack = 1'b1;
        step();
        chk("prio_bubble_valid",   8'(ifa.valid), 8'h00);
        chk("prio_bubble_pending", ifa.pending, 8'h01);
        step();
        ifa.ack = 1'b0;
        chk("prio_idle_ack_pending", ifa.pending, 8'h01);
        chk("prio_second_valid",     8'(ifa.valid), 8'h01);
        ifa.ack = 1'b1;
        step();
        ifa.ack = 1'b0;
        chk("prio_drained", ifa.pending, 8'h00);

        // No preemption: index 2 held while index 7 arrives.
        ifa.en = 1'b1; ifa.req = 8'h04; expq_a.push_back(3'b010);
        step();
        ifa.req = 8'h00; ifa.en = 1'b0;
        step();
        ifa.en = 1'b1; ifa.req = 8'h80;
        step();
        ifa.en = 1'b0; ifa.req = 8'h00;
        chk("nopre_pending", ifa.pending, 8'h84);
        chk("nopre_code",    8'(ifa.code), 8'h02);
        expq_a.push_back(3'b111);
        ifa.ack = 1'b1;
        step();
        ifa.ack = 1'b0;
        chk("nopre_after_ack", ifa.pending, 8'h80);
        step();
        ifa.ack = 1'b1;
        step();
        ifa.ack = 1'b0;
        chk("nopre_drained", ifa.pending, 8'h00);

        // Set/clear collision on index 3 (code 110), then a lost request.
        ifa.en = 1'b1; ifa.req = 8'h08; expq_a.push_back(3'b110);
        step();
        ifa.en = 1'b0; ifa.req = 8'h00;
        step();
        ifa.ack = 1'b1; ifa.en = 1'b1; ifa.req = 8'h08; expq_a.push_back(3'b110);
        step();
        ifa.ack = 1'b0; ifa.en = 1'b0; ifa.req = 8'h00;
        chk("coll_pending", ifa.pending, 8'h08);
        chk("coll_lost",    8'(ifa.lost), 8'h00);
        chk("coll_valid",   8'(ifa.valid), 8'h00);
        step();
        ifa.en = 1'b1; ifa.req = 8'h08;
        step();
        ifa.en = 1'b0; ifa.req = 8'h00;
        chk("lost_pulse", 8'(ifa.lost), 8'h01);
        step();
        chk("lost_clear", 8'(ifa.lost), 8'h00);
        ifa.ack = 1'b1;
        step();
        ifa.ack = 1'b0;
        chk("coll_drained", ifa.pending, 8'h00);

        // en gating, then reset while presenting with all bits pending.
        ifa.en = 1'b0; ifa.req = 8'hFF;
        step();
        chk("gate_pending", ifa.pending, 8'h00);
        chk("gate_valid",   8'(ifa.valid), 8'h00);
        ifa.en = 1'b1; expq_a.push_back(3'b111);
        step();
        ifa.en = 1'b0; ifa.req = 8'h00;
        step();
        chk("full_pending", ifa.pending, 8'hFF);
        chk("full_valid",   8'(ifa.valid), 8'h01);
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        chk("mid_rst_pending", ifa.pending, 8'h00);
        chk("mid_rst_valid",   8'(ifa.valid), 8'h00);
        chk("mid_rst_code",    8'(ifa.code),  8'h00);
        chk("mid_rst_lost",    8'(ifa.lost),  8'h00);
        step(); step();
        chk("post_rst_valid", 8'(ifa.valid), 8'h00);
        ifa.en = 1'b1; ifa.req = 8'h02; expq_a.push_back(3'b100);
        step();
        ifa.en = 1'b0; ifa.req = 8'h00;
        step();
        ifa.ack = 1'b1;
        step();
        ifa.ack = 1'b0;
        chk("post_rst_drained", ifa.pending, 8'h00);

        // HIGH_FIRST=0: index 0 before index 7.
        rst_b = 1'b0;
        ifb.en = 1'b1; ifb.req = 8'h81;
        expq_b.push_back(3'b000); expq_b.push_back(3'b111);
        step();
        ifb.en = 1'b0; ifb.req = 8'h00;
        step();
        ifb.ack = 1'b1;
        step();
        ifb.ack = 1'b0;
        chk("low_first_pending", ifb.pending, 8'h80);
        step();
        ifb.ack = 1'b1;
        step();
        ifb.ack = 1'b0;
        chk("low_first_drained", ifb.pending, 8'h00);
        chk("low_first_valid",   8'(ifb.valid), 8'h00);

        // Every expected grant must have been presented.
        for (int i = 0; i < 10; i++) begin
            if (expq_a.size() == 0 && expq_b.size() == 0) break;
            step();
        end
        chk("queue_a_drained", 8'(expq_a.size()), 8'h00);
        chk("queue_b_drained", 8'(expq_b.size()), 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/priority_encoder8to3.md
PRIORITY_ENCODER8TO3 -- requirements
Module: priority_encoder8to3

Interface
REQ-001 SHALL have parameter HIGH_FIRST, default 1, meaning 1: index 7 is highest priority; 0: index 0 is highest priority.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port en  input  1  request-capture enable; 0 ignores req.
REQ-005 SHALL have port req  input  8  request lines, one bit per index 0..7.
REQ-006 SHALL have port ack  input  1  consumer accepts presented code.
REQ-007 SHALL have port code  output  3  encoded granted index; code[0]=index bit 2 (MSB), code[1]=index bit 1, code[2]=index bit 0 (LSB).
REQ-008 SHALL have port valid  output  1  code holds a pending, unacknowledged index.
REQ-009 SHALL have port pending  output  8  registered pending-request vector.
REQ-010 SHALL have port lost  output  1  one-cycle pulse: a request hit an already-pending bit.
REQ-011 SHALL use one clock and a synchronous active-high reset; no other clock or async input.

Function
REQ-012 SHALL, at each edge with en=1, set pending[i] for every req[i]=1; en=0 leaves pending unchanged except by ack.
REQ-013 SHALL implement two states: IDLE (valid=0) and PRESENT (valid=1).
REQ-014 SHALL, in IDLE at an edge where pending (pre-edge value) is nonzero, load code with the highest-priority pending index per HIGH_FIRST, set valid=1, enter PRESENT.
REQ-015 SHALL, in IDLE with pending=0, remain in IDLE with code unchanged.
REQ-016 SHALL hold code and valid stable in PRESENT until ack; newly arriving higher-priority requests SHALL NOT preempt.
REQ-017 SHALL, in PRESENT at an edge with ack=1, clear pending[code], set valid=0, enter IDLE; next grant earliest one edge later (one-cycle bubble).
REQ-018 SHALL ignore ack while valid=0.
REQ-019 SHALL, when set (REQ-012) and clear (REQ-017) hit the same bit at the same edge, leave the bit set (set wins); lost SHALL NOT pulse for that bit.
REQ-020 SHALL pulse lost=1 for the cycle following any edge where en=1, req[i]=1, and pending[i] was already 1 and not being cleared; otherwise lost=0.
REQ-021 SHALL have latency: req sampled at edge N -> pending[i]=1 after N; valid=1 with code after edge N+1 (if IDLE and i wins).
REQ-022 SHALL keep code at its last value after ack (not forced to 0); consumers SHALL qualify code with valid.
REQ-023 SHALL, with all 8 bits pending, drain in strict priority order, one grant per ack, 7..0 when HIGH_FIRST=1.

Reset
REQ-024 SHALL, at any edge with reset=1, force pending=0, code=0, valid=0, lost=0, state IDLE, overriding en, req, ack.
REQ-025 SHALL, if reset asserts during PRESENT, discard the presented index and all pending requests; no grant until new req after reset deasserts.

Verification
REQ-026 Single request: reset, en=1, req=8'h20 for one edge -> pending=8'h20 next cycle; one edge later valid=1, code=3'b101 (index 5: code[0]=1,code[1]=0,code[2]=1); ack -> valid=0, pending=0.
REQ-027 Priority, HIGH_FIRST=1: req=8'h81 at one edge -> code=3'b111 (index 7); ack -> bubble cycle, then code=3'b000 (index 0); ack -> pending=0; repeat HIGH_FIRST=0 -> index 0 first, then 7.
REQ-028 No preemption: index 2 presented, then req=8'h80 -> code stays index 2 (3'b010), pending=8'h84; after ack, index 7 presented.
REQ-029 Set/clear collision and lost: index 3 presented, ack=1 and req=8'h08 same edge -> pending[3]=1, lost=0, index 3 re-presented after bubble; req=8'h08 again while pending -> lost=1 for one cycle.
REQ-030 en gating and reset mid-operation: en=0, req=8'hFF -> pending stays 0, valid stays 0; with pending=8'hFF and valid=1, reset one cycle -> all outputs 0 next cycle, no grant until new en=1 request.
